// File: rtl/fpu_responder.sv
// fpu_responder: fixed-latency sign-injection, compare and min/max responder
module fpu_responder #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] fpu_data_a,
  input  logic [31:0] fpu_data_b,
  input  logic [7:0]  fpu_data_c,
  input  logic [9:0]  fpu_in_valid,
  output logic [31:0] fpu_out,
  output logic        fpu_out_valid,
  output logic [7:0]  out_tag,
  output logic        proto_err
);
  logic               nan_a, nan_b, both_zero, lt, eq, ordered, one_hot, multi;
  logic [31:0]        min_v, max_v, res;
  logic [LATENCY-1:0] vld, vin;
  logic [31:0]        dat [LATENCY];
  logic [31:0]        din [LATENCY];
  logic [7:0]         tag [LATENCY];
  logic [7:0]         tin [LATENCY];
  assign nan_a     = &fpu_data_a[30:23] && |fpu_data_a[22:0];
  assign nan_b     = &fpu_data_b[30:23] && |fpu_data_b[22:0];
  assign ordered   = !nan_a && !nan_b;
  assign both_zero = ~|{fpu_data_a[30:0], fpu_data_b[30:0]};
  // sign-magnitude order: larger magnitude is smaller when both are negative
  assign lt = both_zero ? 1'b0 :
              fpu_data_a[31] != fpu_data_b[31] ? fpu_data_a[31] :
              fpu_data_a[31] ? fpu_data_a[30:0] > fpu_data_b[30:0] :
              fpu_data_a[30:0] < fpu_data_b[30:0];
  assign eq = both_zero || fpu_data_a == fpu_data_b;
  assign min_v = nan_a && nan_b ? 32'h7FC0_0000 :
                 nan_a ? fpu_data_b :
                 nan_b ? fpu_data_a :
                 both_zero ? {fpu_data_a[31] | fpu_data_b[31], 31'd0} :
                 lt ? fpu_data_a : fpu_data_b;
  assign max_v = nan_a && nan_b ? 32'h7FC0_0000 :
                 nan_a ? fpu_data_b :
                 nan_b ? fpu_data_a :
                 both_zero ? {fpu_data_a[31] & fpu_data_b[31], 31'd0} :
                 lt ? fpu_data_b : fpu_data_a;
  assign res = fpu_in_valid[0] ? {~fpu_data_a[31], fpu_data_a[30:0]} :
               fpu_in_valid[1] ? {1'b0, fpu_data_a[30:0]} :
               fpu_in_valid[2] ? {fpu_data_b[31], fpu_data_a[30:0]} :
               fpu_in_valid[3] ? {~fpu_data_b[31], fpu_data_a[30:0]} :
               fpu_in_valid[4] ? {31'd0, ordered && eq} :
               fpu_in_valid[5] ? {31'd0, ordered && lt} :
               fpu_in_valid[6] ? {31'd0, ordered && (lt || eq)} :
               fpu_in_valid[7] ? fpu_data_a :
               fpu_in_valid[8] ? min_v : max_v;
  assign multi   = |(fpu_in_valid & (fpu_in_valid - 10'd1));
  assign one_hot = |fpu_in_valid && !multi;
  assign vin     = LATENCY'({vld, one_hot});
  always_comb begin
    din[0] = res;
    tin[0] = fpu_data_c;
    for (int i = 1; i < LATENCY; i++) begin
      din[i] = dat[i-1];
      tin[i] = tag[i-1];
    end
  end
  // data/tag stages only load with a valid entry, so the last stage holds its value when idle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld       <= '0;
      proto_err <= 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
        dat[i] <= '0;
        tag[i] <= '0;
      end
    end else begin
      vld       <= vin;
      proto_err <= proto_err | multi;
      for (int i = 0; i < LATENCY; i++) begin
        if (vin[i]) begin
          dat[i] <= din[i];
          tag[i] <= tin[i];
        end
      end
    end
  end
  assign fpu_out       = dat[LATENCY-1];
  assign out_tag       = tag[LATENCY-1];
  assign fpu_out_valid = vld[LATENCY-1];
endmodule

// File: tb/tb_fpu_responder.sv
// tb_fpu_responder: scoreboard bench driving LATENCY 2, 1 and 8 instances with shared stimulus
module tb_fpu_responder;
  logic        clk = 0, rstn = 0;
  logic [31:0] a = 0, b = 0;
  logic [7:0]  c = 0;
  logic [9:0]  iv = 0;
  int          cyc = 0, tests = 0, fails = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    logic [31:0] d;
    logic [7:0]  t;
    int          c;
  } exp_t;
  exp_t        exp_q[$];
  logic [31:0] outs [3];
  logic        ov   [3];
  logic [7:0]  ot   [3];
  logic        pe   [3];
  function automatic void chk(string n, int g, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s inst%0d cyc%0d: got %h want %h", n, g, cyc, act, req);
    end
  endfunction
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 8;
    logic [31:0] o;
    logic        v, p;
    logic [7:0]  t;
    int          ptr = 0;
    logic [31:0] last_d = 0;
    logic [7:0]  last_t = 0;
    fpu_responder #(.LATENCY(L)) dut (
      .clk(clk), .rstn(rstn), .fpu_data_a(a), .fpu_data_b(b), .fpu_data_c(c),
      .fpu_in_valid(iv), .fpu_out(o), .fpu_out_valid(v), .out_tag(t), .proto_err(p)
    );
    assign outs[g] = o;
    assign ov[g]   = v;
    assign ot[g]   = t;
    assign pe[g]   = p;
    always @(negedge clk) begin
      if (!rstn) begin
        ptr    = exp_q.size();
        last_d = 0;
        last_t = 0;
        chk("reset_out", g, o, 0);
        chk("reset_valid", g, 32'(v), 0);
        chk("reset_tag", g, 32'(t), 0);
        chk("reset_perr", g, 32'(p), 0);
      end else begin
        while (ptr < exp_q.size() && cyc > exp_q[ptr].c + L) begin
          tests++;
          fails++;
          $display("FAIL missing_result inst%0d cyc%0d: got none want tag %h", g, cyc, exp_q[ptr].t);
          ptr++;
        end
        if (v) begin
          if (ptr < exp_q.size() && cyc == exp_q[ptr].c + L) begin
            chk("result", g, o, exp_q[ptr].d);
            chk("tag", g, 32'(t), 32'(exp_q[ptr].t));
            ptr++;
          end else chk("unexpected_valid", g, 32'(v), 0);
          last_d = o;
          last_t = t;
        end else begin
          chk("hold_out", g, o, last_d);
          chk("hold_tag", g, 32'(t), 32'(last_t));
        end
      end
    end
  end
  function automatic logic is_nan(logic [31:0] x);
    return x[30:23] == 8'hFF && x[22:0] != 0;
  endfunction
  function automatic real to_r(logic [31:0] x);
    real m = real'(x[22:0]);
    int  e = int'(x[30:23]);
    real r = (e == 0) ? m * (2.0 ** (-149)) : (e == 255) ? 1.0e300 : (m + 8388608.0) * (2.0 ** (e - 150));
    return x[31] ? -r : r;
  endfunction
  function automatic logic [31:0] model(int op, logic [31:0] x, logic [31:0] y);
    real rx = to_r(x), ry = to_r(y);
    logic nan = is_nan(x) || is_nan(y);
    case (op)
      0: return {~x[31], x[30:0]};
      1: return {1'b0, x[30:0]};
      2: return {y[31], x[30:0]};
      3: return {~y[31], x[30:0]};
      4: return {31'd0, !nan && rx == ry};
      5: return {31'd0, !nan && rx < ry};
      6: return {31'd0, !nan && rx <= ry};
      7: return x;
      default: begin
        if (is_nan(x) && is_nan(y)) return 32'h7FC0_0000;
        if (is_nan(x)) return y;
        if (is_nan(y)) return x;
        if (rx == ry) begin
          if (rx != 0.0) return x;
          return (op == 8) == (x[31] == 1'b1) ? x : y;
        end
        return (op == 8) == (rx < ry) ? x : y;
      end
    endcase
  endfunction
  function automatic logic [31:0] rv();
    logic [31:0] sp [13] = '{32'h0, 32'h8000_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h7F80_0000,
                             32'hFF80_0000, 32'h7FC0_0000, 32'h7F80_0001, 32'hFFC0_0001,
                             32'h0000_0001, 32'h8000_0001, 32'h007F_FFFF, 32'h4000_0000};
    return $urandom_range(1) == 1 ? sp[$urandom_range(12)] : $urandom;
  endfunction
  task automatic issue(logic [9:0] v, logic [31:0] x, logic [31:0] y, logic [7:0] t,
                       bit k = 0, logic [31:0] kv = 0);
    exp_t e;
    @(posedge clk);
    #1;
    iv = v;
    a  = x;
    b  = y;
    c  = t;
    if (rstn && $onehot(v)) begin
      e.d = k ? kv : model($clog2(v), x, y);
      e.t = t;
      e.c = cyc;
      exp_q.push_back(e);
    end
  endtask
  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      iv = 0;
    end
  endtask
  initial begin
    logic [31:0] x;
    repeat (5) begin
      @(posedge clk);
      #1;
      iv = 10'($urandom);
      a  = $urandom;
      b  = $urandom;
      c  = 8'($urandom);
    end
    @(posedge clk);
    #1;
    iv   = 0;
    rstn = 1;
    issue(10'h001, 32'h3F80_0000, 32'h0, 8'h5A, 1, 32'hBF80_0000);
    idle(10);
    issue(10'h010, 32'h8000_0000, 32'h0000_0000, 8'h01, 1, 32'h1);
    issue(10'h020, 32'hBF80_0000, 32'h3F80_0000, 8'h02, 1, 32'h1);
    issue(10'h040, 32'h7FC0_0001, 32'h3F80_0000, 8'h03, 1, 32'h0);
    issue(10'h100, 32'h0000_0000, 32'h8000_0000, 8'h04, 1, 32'h8000_0000);
    issue(10'h200, 32'h7FC0_0000, 32'h4000_0000, 8'h05, 1, 32'h4000_0000);
    issue(10'h200, 32'h7FC0_0001, 32'hFFC0_0000, 8'h06, 1, 32'h7FC0_0000);
    issue(10'h200, 32'h8000_0000, 32'h0000_0000, 8'h07, 1, 32'h0000_0000);
    issue(10'h100, 32'h8000_0000, 32'h0000_0000, 8'h08, 1, 32'h8000_0000);
    idle(10);
    for (int i = 0; i < 10; i++) issue(10'(1) << i, rv(), rv(), 8'(i));
    idle(10);
    repeat (300) begin
      if ($urandom_range(3) == 0) idle(1 + $urandom_range(2));
      x = rv();
      issue(10'(1) << $urandom_range(9), x, $urandom_range(9) == 0 ? x : rv(), 8'($urandom));
    end
    idle(12);
    for (int i = 0; i < 3; i++) issue(10'h080, rv(), rv(), 8'(8'hE0 + i));
    @(posedge clk);
    #1;
    rstn = 0;
    idle(2);
    rstn = 1;
    idle(12);
    issue(10'h080, 32'h1234_5678, 32'h0, 8'h77, 1, 32'h1234_5678);
    idle(10);
    issue(10'h002, 32'hC040_0000, 32'h0, 8'hA1, 1, 32'h4040_0000);
    issue(10'h011, rv(), rv(), 8'hA2);
    @(negedge clk);
    for (int g = 0; g < 3; g++) chk("perr_before", g, 32'(pe[g]), 0);
    issue(10'h008, 32'h3F80_0000, 32'h3F80_0000, 8'hA3, 1, 32'hBF80_0000);
    @(negedge clk);
    for (int g = 0; g < 3; g++) chk("perr_set", g, 32'(pe[g]), 1);
    idle(100);
    @(negedge clk);
    for (int g = 0; g < 3; g++) chk("perr_sticky", g, 32'(pe[g]), 1);
    idle(10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
